// File: rtl/cvm300_reg_sequencer_if.sv
// Host/transmitter signal bundle for the CVM300 register sequencer.
// slave is the sequencer's view; master is the host/transmitter side.
interface cvm300_reg_sequencer_if;
  logic       tbl_we;
  logic [3:0] tbl_addr;
  logic [6:0] tbl_reg_addr;
  logic [7:0] tbl_reg_data;
  logic [4:0] num_entries;
  logic       start;
  logic       verify_en;
  logic [7:0] A1;
  logic [7:0] D1;
  logic [2:0] R_W;
  logic [7:0] MSB;
  logic       busy;
  logic       done;
  logic       err;
  logic [4:0] err_count;
  logic [3:0] err_index;

  modport slave (
    input  tbl_we, tbl_addr, tbl_reg_addr, tbl_reg_data, num_entries,
           start, verify_en, MSB,
    output A1, D1, R_W, busy, done, err, err_count, err_index
  );

  modport master (
    output tbl_we, tbl_addr, tbl_reg_addr, tbl_reg_data, num_entries,
           start, verify_en, MSB,
    input  A1, D1, R_W, busy, done, err, err_count, err_index
  );
endinterface

// File: rtl/cvm300_reg_sequencer.sv
// CVM300 register sequencer: replays a 16-entry (address, data) table as
// one-cycle write requests to the SPI transmitter, optionally reading each
// register back and counting mismatches.
module cvm300_reg_sequencer #(
  parameter int TXN_CYCLES = 36
) (
  input logic                    FSM_Clk,
  input logic                    Reset_n,
  cvm300_reg_sequencer_if.slave  bus
);

  localparam int CW = $clog2(TXN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(TXN_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SETTLE = CW'(TXN_CYCLES);

  typedef enum logic [1:0] {SETTLE, IDLE, WR_WAIT, RD_WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    idx, idx_nxt, idx_inc;
  logic [4:0]    n_lat, n_nxt, n_clamp;
  logic          ver, ver_nxt;
  logic [7:0]    a1, a1_nxt, d1, d1_nxt;
  logic [2:0]    rw, rw_nxt;
  logic          busy, busy_nxt, done, done_nxt;
  logic          err, err_nxt;
  logic [4:0]    errc, errc_nxt;
  logic [3:0]    erri, erri_nxt;
  logic          advance;

  // Table storage is deliberately not reset so contents survive Reset_n.
  logic [14:0] tbl [16];

  assign idx_inc = idx + 4'd1;
  assign n_clamp = (bus.num_entries > 5'd16) ? 5'd16 : bus.num_entries;

  assign bus.A1        = a1;
  assign bus.D1        = d1;
  assign bus.R_W       = rw;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err;
  assign bus.err_count = errc;
  assign bus.err_index = erri;

  // Host table load, locked out while a run or the post-reset settle is active.
  always_ff @(posedge FSM_Clk) begin
    if (bus.tbl_we && !busy)
      tbl[bus.tbl_addr] <= {bus.tbl_reg_addr, bus.tbl_reg_data};
  end

  // State and output registers; everything returns to 0 and SETTLE on reset.
  always_ff @(posedge FSM_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= SETTLE;
      cnt   <= '0;
      idx   <= '0;
      n_lat <= '0;
      ver   <= 1'b0;
      a1    <= '0;
      d1    <= '0;
      rw    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      errc  <= '0;
      erri  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      n_lat <= n_nxt;
      ver   <= ver_nxt;
      a1    <= a1_nxt;
      d1    <= d1_nxt;
      rw    <= rw_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
      errc  <= errc_nxt;
      erri  <= erri_nxt;
    end
  end

  // Next-state logic: R_W and done are single-cycle pulses, everything else holds.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    n_nxt     = n_lat;
    ver_nxt   = ver;
    a1_nxt    = a1;
    d1_nxt    = d1;
    rw_nxt    = 3'd0;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    err_nxt   = err;
    errc_nxt  = errc;
    erri_nxt  = erri;
    advance   = 1'b0;

    case (state)
      SETTLE: begin
        busy_nxt = 1'b1;
        if (cnt == CNT_SETTLE) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      IDLE: begin
        if (bus.start) begin
          err_nxt  = 1'b0;
          errc_nxt = '0;
          erri_nxt = '0;
          ver_nxt  = bus.verify_en;
          n_nxt    = n_clamp;
          idx_nxt  = '0;
          if (n_clamp == 5'd0) begin
            done_nxt = 1'b1;
          end else begin
            a1_nxt    = {1'b0, tbl[0][14:8]};
            d1_nxt    = tbl[0][7:0];
            rw_nxt    = 3'd1;
            cnt_nxt   = CNT_RELOAD;
            busy_nxt  = 1'b1;
            state_nxt = WR_WAIT;
          end
        end
      end
      WR_WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (ver) begin
          rw_nxt    = 3'd2;
          cnt_nxt   = CNT_RELOAD;
          state_nxt = RD_WAIT;
        end else begin
          advance = 1'b1;
        end
      end
      RD_WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          if (bus.MSB != d1) begin
            err_nxt  = 1'b1;
            errc_nxt = errc + 5'd1;
            if (!err)
              erri_nxt = idx;
          end
          advance = 1'b1;
        end
      end
      default: state_nxt = SETTLE;
    endcase

    if (advance) begin
      if ({1'b0, idx} == n_lat - 5'd1) begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end else begin
        idx_nxt   = idx_inc;
        a1_nxt    = {1'b0, tbl[idx_inc][14:8]};
        d1_nxt    = tbl[idx_inc][7:0];
        rw_nxt    = 3'd1;
        cnt_nxt   = CNT_RELOAD;
        state_nxt = WR_WAIT;
      end
    end
  end

endmodule

// File: doc/cvm300_reg_sequencer.md
# cvm300_reg_sequencer

Upstream command stage for the CVM300 SPI transmitter. It holds a host-loaded table of up to 16 sensor register (address, data) pairs. On a start pulse it issues the pairs one by one as single-cycle write requests on the transmitter's A1/D1/R_W inputs. When verification is enabled it reads each register back and compares the returned byte (MSB) against the written value, flagging mismatches.

## Interface
Parameters:
- TXN_CYCLES, 36: FSM_Clk cycles reserved per SPI transaction, counted from the issue edge to the next allowed issue edge. Must be ≥ 36.

Ports:
- FSM_Clk  in  1  sole clock; identical to the transmitter's FSM clock.
- Reset_n  in  1  asynchronous, active-low reset.
- tbl_we  in  1  table write strobe.
- tbl_addr  in  4  table entry index.
- tbl_reg_addr  in  7  sensor register address to store.
- tbl_reg_data  in  8  sensor register data to store.
- num_entries  in  5  entries to run (0..16); values above 16 are clamped to 16.
- start  in  1  begin sequence; sampled high in IDLE.
- verify_en  in  1  read back and compare after each write; sampled at start.
- A1  out  8  to transmitter; {1'b0, reg_addr}.
- D1  out  8  to transmitter; write data.
- R_W  out  3  to transmitter; 1 = write request, 2 = read request, 0 = idle.
- MSB  in  8  read data returned by the transmitter.
- busy  out  1  sequence or post-reset settle in progress.
- done  out  1  one-cycle pulse when the sequence completes.
- err  out  1  sticky; at least one verify mismatch since the last start.
- err_count  out  5  number of mismatches in the current run.
- err_index  out  4  table index of the first mismatch.

## Operation
- Table: 16 × 15-bit storage, written on tbl_we when not busy. Writes while busy are ignored. Contents are not reset; they are preserved across Reset_n.
- States: SETTLE, IDLE, WR_WAIT, RD_WAIT.
- Reset (async): all outputs go to 0 immediately (R_W = 0, A1 = D1 = 0, busy = done = err = 0, err_count = err_index = 0). Index and counter clear. State becomes SETTLE.
- SETTLE: busy = 1. Counts TXN_CYCLES cycles so that any transmitter transaction interrupted by the reset can drain, then enters IDLE. A start during SETTLE is ignored.
- IDLE: on start, clear err, err_count and err_index. Latch verify_en and the clamped N. Set busy = 1.
  - If N = 0: done = 1 on the same edge, busy stays 0, remain in IDLE.
  - Otherwise: load entry 0 into A1/D1, drive R_W = 1, load counter = TXN_CYCLES-1, go to WR_WAIT.
- WR_WAIT: R_W returns to 0 on the first edge after issue, so R_W is high for exactly one cycle. A1/D1 hold stable. The counter decrements each cycle. At counter = 0:
  - If verify is enabled: drive R_W = 2 with the same A1, reload the counter, go to RD_WAIT.
  - Otherwise: advance to the next entry.
- RD_WAIT: R_W pulses for one cycle, as in WR_WAIT. At counter = 0, compare MSB to D1.
  - On mismatch: err = 1 and err_count += 1. If this is the first mismatch, err_index = current index.
  - Then advance to the next entry.
- Advance: if index = N-1, assert done = 1 and busy = 0, go to IDLE, and leave A1/D1 holding the last values. Otherwise increment index, load the next entry, and issue a write on the same edge (no idle gap).
- start while busy is ignored. A table write during a run has no effect on the run.
- err_count never exceeds 16, so it needs no saturation.

## Timing
- Issue edge E: R_W is nonzero during cycle E→E+1 only. The transmitter leaves its idle state at E+1 and returns at E+35. The next issue is at E+TXN_CYCLES (E+36 at the default), which gives one cycle of margin.
- MSB is final by E+33. The compare occurs at E+TXN_CYCLES.
- Start sampled at edge 0:
  - Without verify: done pulses at edge N·TXN_CYCLES.
  - With verify: done pulses at edge 2·N·TXN_CYCLES.
- done is high for exactly one cycle. busy falls on the same edge that done rises.
- After Reset_n deasserts, busy = 1 for TXN_CYCLES cycles, and the earliest accepted start is on the following edge.

## Test plan
- Load 3 entries {(0x3A,0x55),(0x01,0xFF),(0x7F,0x00)}, start with verify_en = 0:
  - Exactly 3 R_W = 1 pulses, at edges 0, 36 and 72, with A1/D1 matching each entry.
  - done at edge 108; no R_W = 2 is ever issued.
- Same table with verify_en = 1 and a transmitter model echoing the written data:
  - Alternating R_W = 1/2 pulses at 36-cycle spacing.
  - done at edge 216; err = 0, err_count = 0.
- Verify run where the model corrupts the reads of entries 1 and 2:
  - err = 1, err_count = 2, err_index = 1.
  - A new start clears all three.
- num_entries = 0 → done the cycle after start, no R_W activity. num_entries = 20 → exactly 16 writes.
- Assert Reset_n low mid-WR_WAIT of entry 1:
  - R_W, busy and done go to 0 asynchronously.
  - busy = 1 for 36 cycles after release, and a start in that window is ignored.
  - Table contents are intact on the next run.
- tbl_we and a second start while busy → table unchanged and run unaffected (checked by the A1/D1 sequence).
